// File: rtl/ula_issue.sv
// rtl/ula_issue.sv - request/result sequencer around an external combinational ALU
// Optional ULA_ISSUE_PIPE_EN: accept the next request on the same edge that drains a result.
module ula_issue #(
   parameter int NUBITS = 32,
   parameter int DIVLAT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [4:0]               req_op,
   input  logic signed [NUBITS-1:0] req_a,
   input  logic signed [NUBITS-1:0] req_b,
   output logic [4:0]               alu_op,
   output logic signed [NUBITS-1:0] alu_in1,
   output logic signed [NUBITS-1:0] alu_in2,
   input  logic signed [NUBITS-1:0] alu_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [NUBITS-1:0]        res_data,
   output logic                     res_cmp,
   output logic                     res_err,
   output logic                     busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] CNT_LOAD = 4'(DIVLAT - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       transfer;

   function automatic logic op_multi(input logic [4:0] op);
      return (op == 5'd4) || (op == 5'd5) || (op == 5'd16);
   endfunction

   function automatic logic op_illegal(input logic [4:0] op);
      return op >= 5'd18;
   endfunction

   function automatic logic op_cmp(input logic [4:0] op);
      return (op >= 5'd13) && (op <= 5'd15);
   endfunction

   always_comb begin
      req_ready = (state == IDLE);
`ifdef ULA_ISSUE_PIPE_EN
      if (state == DONE) begin
         req_ready = res_ready;
      end
`else
`endif
   end

   assign transfer  = req_valid & req_ready;
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         res_data <= '0;
         res_cmp  <= 1'b0;
         res_err  <= 1'b0;
         alu_op   <= 5'd0;
         alu_in1  <= '0;
         alu_in2  <= '0;
      end else if (transfer) begin
         // A transfer only happens in IDLE or a draining DONE, so it wins over the state actions.
         alu_op  <= req_op;
         alu_in1 <= req_a;
         alu_in2 <= req_b;
         if (op_illegal(req_op)) begin
            state    <= DONE;
            res_err  <= 1'b1;
            res_data <= '0;
            res_cmp  <= 1'b0;
         end else if (op_multi(req_op)) begin
            state   <= WAIT;
            cnt     <= CNT_LOAD;
            res_err <= 1'b0;
         end else begin
            state   <= EXEC;
            res_err <= 1'b0;
         end
      end else begin
         case (state)
            EXEC: begin
               res_data <= alu_out;
               res_cmp  <= op_cmp(alu_op) ? alu_out[0] : 1'b0;
               state    <= DONE;
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  res_data <= alu_out;
                  res_cmp  <= op_cmp(alu_op) ? alu_out[0] : 1'b0;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_issue.sv
// tb/tb_ula_issue.sv - scoreboard bench for ula_issue with a behavioural ALU
module tb_ula_issue;

   logic               clk;
   logic               rst;
   logic               req_valid;
   logic               req_ready;
   logic [4:0]         req_op;
   logic signed [31:0] req_a;
   logic signed [31:0] req_b;
   logic [4:0]         alu_op;
   logic signed [31:0] alu_in1;
   logic signed [31:0] alu_in2;
   logic signed [31:0] alu_out;
   logic               res_valid;
   logic               res_ready;
   logic [31:0]        res_data;
   logic               res_cmp;
   logic               res_err;
   logic               busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        cmp;
      logic        err;
   } exp_t;

   exp_t sb[$];

`ifdef ULA_ISSUE_PIPE_EN
   localparam int EXP_GAP = 2;
`else
   localparam int EXP_GAP = 3;
`endif

   ula_issue #(.NUBITS(32), .DIVLAT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_cmp(res_cmp), .res_err(res_err),
      .busy(busy)
   );

   function automatic logic signed [31:0] alu_f(input logic [4:0] op,
                                                input logic signed [31:0] a,
                                                input logic signed [31:0] b);
      case (op)
         5'd1:    return a;
         5'd2:    return a + b;
         5'd3:    return a - b;
         5'd4:    return (b == 0) ? 32'sd0 : a / b;
         5'd5:    return (b == 0) ? 32'sd0 : a % b;
         5'd13:   return (a < b) ? 32'sd1 : 32'sd0;
         5'd14:   return (a > b) ? 32'sd1 : 32'sd0;
         5'd15:   return (a == b) ? 32'sd1 : 32'sd0;
         5'd16:   return (a < 0) ? -a : a;
         5'd17:   return a ^ b;
         default: return 32'sd0;
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_in1, alu_in2);

   function automatic exp_t make_exp(input logic [4:0] op,
                                     input logic signed [31:0] a,
                                     input logic signed [31:0] b);
      exp_t e;
      logic signed [31:0] r;
      r = alu_f(op, a, b);
      if (op >= 5'd18) begin
         e.data = 32'd0;
         e.cmp  = 1'b0;
         e.err  = 1'b1;
      end else begin
         e.data = r;
         e.err  = 1'b0;
         e.cmp  = (op >= 5'd13 && op <= 5'd15) ? r[0] : 1'b0;
      end
      return e;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   // Issue one op, wait for its result, compare against the scoreboard.
   task automatic run_op(input logic [4:0] op, input logic signed [31:0] a,
                         input logic signed [31:0] b, input int exp_lat, output int busy_n);
      int   lat;
      int   guard;
      exp_t e;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_idle op=%0d got %b want 1", op, req_ready);
      end
      sb.push_back(make_exp(op, a, b));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_op = 5'd9; req_a = 32'sh0bad0bad; req_b = 32'sh0000_0003;
      lat = 1; busy_n = 0;
      while (res_valid !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency op=%0d got %0d want %0d", op, lat, exp_lat);
      end
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty op=%0d got 0 entries want 1", op);
      end else begin
         e = sb.pop_front();
         if (res_valid === 1'b1) begin
            checks++;
            if (res_data !== e.data) begin
               errors++;
               $display("FAIL res_data op=%0d got %0d want %0d", op, $signed(res_data), $signed(e.data));
            end
            checks++;
            if (res_cmp !== e.cmp) begin
               errors++;
               $display("FAIL res_cmp op=%0d got %b want %b", op, res_cmp, e.cmp);
            end
            checks++;
            if (res_err !== e.err) begin
               errors++;
               $display("FAIL res_err op=%0d got %b want %b", op, res_err, e.err);
            end
            checks++;
            if (alu_in1 !== a || alu_op !== op) begin
               errors++;
               $display("FAIL alu_hold op=%0d got op=%0d in1=%0d want op=%0d in1=%0d", op, alu_op, alu_in1, op, a);
            end
         end
      end
      guard = 0;
      while (busy === 1'b1 && guard < 40) begin
         busy_n++;
         guard++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'd0 || res_cmp !== 1'b0 ||
          res_err !== 1'b0 || alu_op !== 5'd0 || alu_in1 !== 32'sd0 || alu_in2 !== 32'sd0) begin
         errors++;
         $display("FAIL reset_state got busy=%b rv=%b data=%0d cmp=%b err=%b op=%0d in1=%0d in2=%0d want all 0",
                  busy, res_valid, res_data, res_cmp, res_err, alu_op, alu_in1, alu_in2);
      end
      rst = 1'b1;
   endtask

   task automatic test_single();
      int bn;
      run_op(5'd2, 32'sd5, 32'sd7, 2, bn);
      checks++;
      if (bn != 2) begin
         errors++;
         $display("FAIL busy_single got %0d want 2", bn);
      end
      run_op(5'd3, 32'sd10, 32'sd3, 2, bn);
      run_op(5'd17, 32'sd5, 32'sd2, 2, bn);
      run_op(5'd0, 32'sd5, 32'sd2, 2, bn);
   endtask

   task automatic test_multi();
      int bn;
      run_op(5'd4, 32'sd100, 32'sd7, 5, bn);
      checks++;
      if (bn != 5) begin
         errors++;
         $display("FAIL busy_div got %0d want 5", bn);
      end
      run_op(5'd5, 32'sd100, 32'sd7, 5, bn);
      run_op(5'd16, -32'sd9, 32'sd0, 5, bn);
   endtask

   task automatic test_cmp();
      int bn;
      run_op(5'd13, -32'sd3, 32'sd2, 2, bn);
      run_op(5'd15, 32'sd9, 32'sd8, 2, bn);
      run_op(5'd14, 32'sd9, 32'sd8, 2, bn);
   endtask

   task automatic test_illegal();
      int bn;
      run_op(5'd20, 32'sd5, 32'sd6, 1, bn);
      run_op(5'd1, 32'sd42, 32'sd0, 2, bn);
      run_op(5'd18, 32'sd1, 32'sd1, 1, bn);
      run_op(5'd31, 32'sd1, 32'sd1, 1, bn);
      run_op(5'd17, 32'sd12, 32'sd3, 2, bn);
   endtask

   task automatic test_stall();
      int   n;
      exp_t e;
      res_ready = 1'b0;
      @(negedge clk);
      req_op = 5'd2; req_a = 32'sd3; req_b = 32'sd4; req_valid = 1'b1;
      e = make_exp(5'd2, 32'sd3, 32'sd4);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_data !== e.data || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall cycle=%0d got rv=%b data=%0d rr=%b want rv=1 data=%0d rr=0",
                     i, res_valid, res_data, req_ready, e.data);
         end
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_release got rv=%b busy=%b want 0 0", res_valid, busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      int   n;
      exp_t e;
      @(negedge clk);
      req_op = 5'd4; req_a = 32'sd100; req_b = 32'sd7; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 32'd0 || res_cmp !== 1'b0 ||
          res_err !== 1'b0 || alu_op !== 5'd0 || alu_in1 !== 32'sd0 || alu_in2 !== 32'sd0) begin
         errors++;
         $display("FAIL reset_async got busy=%b rv=%b data=%0d op=%0d in1=%0d in2=%0d want all 0",
                  busy, res_valid, res_data, alu_op, alu_in1, alu_in2);
      end
      @(negedge clk);
      rst = 1'b1;
      req_op = 5'd1; req_a = 32'sd42; req_b = 32'sd0; req_valid = 1'b1;
      e = make_exp(5'd1, 32'sd42, 32'sd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || alu_in1 !== 32'sd42) begin
         errors++;
         $display("FAIL accept_after_reset got busy=%b in1=%0d want 1 42", busy, alu_in1);
      end
      n = 1;
      while (res_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 2 || res_data !== e.data) begin
         errors++;
         $display("FAIL post_reset_result got lat=%0d data=%0d want lat=2 data=%0d", n, res_data, e.data);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      int   n_sent;
      int   n_got;
      int   cyc;
      int   last_cyc;
      logic committed;
      exp_t e;
      n_sent = 0; n_got = 0; cyc = 0; last_cyc = 0; committed = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      req_op = 5'd2; req_a = 32'sd1; req_b = 32'sd3; req_valid = 1'b1;
      while (n_got < N && cyc < 200) begin
         if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL stream_extra got result %0d want none", res_data);
            end else begin
               e = sb.pop_front();
               checks++;
               if (res_data !== e.data || res_err !== 1'b0) begin
                  errors++;
                  $display("FAIL stream_data idx=%0d got %0d want %0d", n_got, res_data, e.data);
               end
            end
            if (n_got > 0) begin
               checks++;
               if (cyc - last_cyc != EXP_GAP) begin
                  errors++;
                  $display("FAIL stream_gap idx=%0d got %0d want %0d", n_got, cyc - last_cyc, EXP_GAP);
               end
            end
            last_cyc = cyc;
            n_got++;
         end
         if (committed) begin
            committed = 1'b0;
            if (n_sent == N) begin
               req_valid = 1'b0;
            end else begin
               req_a = 32'(10 * n_sent + 1);
               req_b = 32'(n_sent + 3);
            end
         end
         if (req_valid === 1'b1 && req_ready === 1'b1) begin
            sb.push_back(make_exp(req_op, req_a, req_b));
            n_sent++;
            committed = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      checks++;
      if (n_got != N || sb.size() != 0) begin
         errors++;
         $display("FAIL stream_count got %0d results %0d pending want %0d results 0 pending", n_got, sb.size(), N);
      end
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_a = 32'sd0; req_b = 32'sd0; res_ready = 1'b1;
      test_reset();
      test_single();
      test_multi();
      test_cmp();
      test_illegal();
      test_stall();
      test_reset_mid_wait();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
